// File: rtl/rf_operand_fetch.sv
// Operand-fetch stage: decodes up to two register addresses from instruction fields,
// reads the internal register file and registers the operands behind a valid/ready output stage.
// Optional macro RF_BYPASS_EN forwards same-edge writeback data into captured and held operands.
module rf_operand_fetch #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FA_LSB  = 0,
  parameter int unsigned FB_LSB  = 3,
  parameter int unsigned FC_LSB  = 13,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [1:0]         sel1,
  input  logic [1:0]         sel2,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [REG_AW-1:0]  out_ra1,
  output logic [REG_AW-1:0]  out_ra2,
  output logic [DATA_W-1:0]  out_rd1,
  output logic [DATA_W-1:0]  out_rd2
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [DATA_W-1:0]  r_rf [NREG];
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [REG_AW-1:0]  r_ra1;
  logic [REG_AW-1:0]  r_ra2;
  logic [DATA_W-1:0]  r_rd1;
  logic [DATA_W-1:0]  r_rd2;

  logic               w_accept;
  logic               w_wr_ok;
  logic [REG_AW-1:0]  w_fa;
  logic [REG_AW-1:0]  w_fb;
  logic [REG_AW-1:0]  w_fc;
  logic [REG_AW-1:0]  w_ra1;
  logic [REG_AW-1:0]  w_ra2;
  logic               w_nil1;
  logic               w_nil2;
  logic [DATA_W-1:0]  w_rd1;
  logic [DATA_W-1:0]  w_rd2;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_wr_ok   = wb_en && !(ZERO_R0 && (wb_addr == '0));

  assign w_fa = in_instr[FA_LSB +: REG_AW];
  assign w_fb = in_instr[FB_LSB +: REG_AW];
  assign w_fc = in_instr[FC_LSB +: REG_AW];

  assign w_nil1 = (sel1 == 2'd3);
  assign w_nil2 = (sel2 == 2'd3);

  always_comb begin
    w_ra1 = '0;
    case (sel1)
      2'd0:    w_ra1 = w_fa;
      2'd1:    w_ra1 = w_fb;
      2'd2:    w_ra1 = w_fc;
      default: w_ra1 = '0;
    endcase
  end

  always_comb begin
    w_ra2 = '0;
    case (sel2)
      2'd0:    w_ra2 = w_fa;
      2'd1:    w_ra2 = w_fb;
      2'd2:    w_ra2 = w_fc;
      default: w_ra2 = '0;
    endcase
  end

  // "none" selector forces zero data even when r0 is an ordinary register
  always_comb begin
    w_rd1 = (w_nil1 || (ZERO_R0 && (w_ra1 == '0))) ? '0 : r_rf[w_ra1];
    w_rd2 = (w_nil2 || (ZERO_R0 && (w_ra2 == '0))) ? '0 : r_rf[w_ra2];
`ifdef RF_BYPASS_EN
    if (!w_nil1 && w_wr_ok && (wb_addr == w_ra1)) w_rd1 = wb_data;
    if (!w_nil2 && w_wr_ok && (wb_addr == w_ra2)) w_rd2 = wb_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

`ifdef RF_BYPASS_EN
  // Remember which held ports were "none" so a write to r0 never leaks into them
  logic r_nil1;
  logic r_nil2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nil1 <= 1'b0;
      r_nil2 <= 1'b0;
    end else if (w_accept) begin
      r_nil1 <= w_nil1;
      r_nil2 <= w_nil2;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ra1   <= '0;
      r_ra2   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= in_instr;
      r_ra1   <= w_ra1;
      r_ra2   <= w_ra2;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
    end else begin
      if (out_ready) r_valid <= 1'b0;
`ifdef RF_BYPASS_EN
      if (r_valid && w_wr_ok) begin
        if (!r_nil1 && (wb_addr == r_ra1)) r_rd1 <= wb_data;
        if (!r_nil2 && (wb_addr == r_ra2)) r_rd2 <= wb_data;
      end
`endif
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_ra1   = r_ra1;
  assign out_ra2   = r_ra2;
  assign out_rd1   = r_rd1;
  assign out_rd2   = r_rd2;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch: vector table for the decode/read function plus
// hand-written stall, collision, refresh and asynchronous-reset sequences.
module tb_rf_operand_fetch;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [1:0]  sel1;
  logic [1:0]  sel2;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [2:0]  out_ra1;
  logic [2:0]  out_ra2;
  logic [7:0]  out_rd1;
  logic [7:0]  out_rd2;

  int checks   = 0;
  int failures = 0;

  rf_operand_fetch #(
    .INSTR_W(16), .REG_AW(3), .DATA_W(8),
    .FA_LSB(0), .FB_LSB(3), .FC_LSB(13), .ZERO_R0(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .sel1(sel1), .sel2(sel2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_ra1(out_ra1), .out_ra2(out_ra2), .out_rd1(out_rd1), .out_rd2(out_rd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [2:0]  ra1;
    logic [7:0]  rd1;
    logic [2:0]  ra2;
    logic [7:0]  rd2;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    // instr A01C: A=4 B=3 C=5; 4039: A=1 B=7 C=2; 001B: A=3 B=3
    tbl[0] = '{16'hA01C, 2'd1, 2'd2, 3'd3, 8'h33, 3'd5, 8'h55};
    tbl[1] = '{16'hA01C, 2'd0, 2'd3, 3'd4, 8'h44, 3'd0, 8'h00};
    tbl[2] = '{16'h0000, 2'd0, 2'd0, 3'd0, 8'h00, 3'd0, 8'h00};
    tbl[3] = '{16'hFFFF, 2'd2, 2'd1, 3'd7, 8'h77, 3'd7, 8'h77};
    tbl[4] = '{16'h4039, 2'd2, 2'd1, 3'd2, 8'h22, 3'd7, 8'h77};
    tbl[5] = '{16'h4039, 2'd3, 2'd0, 3'd0, 8'h00, 3'd1, 8'h11};
    tbl[6] = '{16'h001B, 2'd0, 2'd1, 3'd3, 8'h33, 3'd3, 8'h33};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; sel1 = '0; sel2 = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_rd1", out_rd1, 0);
    chk("rst_out_rd2", out_rd2, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 1; i < 8; i++) wr(3'(i), 8'(8'h11 * i));
    wr(3'd0, 8'hFF);

    // streaming: one accept per edge
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_instr = tbl[i].instr; sel1 = tbl[i].s1; sel2 = tbl[i].s2;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_instr", i), out_instr, tbl[i].instr);
      chk($sformatf("v%0d_ra1", i), out_ra1, tbl[i].ra1);
      chk($sformatf("v%0d_rd1", i), out_rd1, tbl[i].rd1);
      chk($sformatf("v%0d_ra2", i), out_ra2, tbl[i].ra2);
      chk($sformatf("v%0d_rd2", i), out_rd2, tbl[i].rd2);
    end

    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_rd1", out_rd1, 8'h33);

    // load then stall three cycles with a new instr waiting
    in_valid = 1'b1; in_instr = 16'hA01C; sel1 = 2'd1; sel2 = 2'd2; out_ready = 1'b0;
    tick();
    chk("stall_load_valid", out_valid, 1);
    chk("stall_load_rd2", out_rd2, 8'h55);
    in_instr = 16'hFFFF; sel1 = 2'd2; sel2 = 2'd1;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h99;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
      tick();
      wb_en = 1'b0;
      chk($sformatf("stall%0d_valid", k), out_valid, 1);
      chk($sformatf("stall%0d_instr", k), out_instr, 16'hA01C);
      chk($sformatf("stall%0d_rd1", k), out_rd1, 8'h33);
      chk($sformatf("stall%0d_rd2", k), out_rd2, BYP ? 8'h99 : 8'h55);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_instr", out_instr, 16'hFFFF);
    chk("release_ra1", out_ra1, 3'd7);
    chk("release_rd1", out_rd1, 8'h77);

    // accept-cycle write/read collision on r3
    in_instr = 16'hA01C; sel1 = 2'd1; sel2 = 2'd2;
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h77;
    tick();
    wb_en = 1'b0;
    chk("coll_rd1", out_rd1, BYP ? 8'h77 : 8'h33);
    chk("coll_rd2", out_rd2, 8'h99);
    tick();
    chk("coll_after_rd1", out_rd1, 8'h77);

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0; in_instr = 16'hFFFF; sel1 = 2'd0; sel2 = 2'd0;
    tick();
    chk("prerst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_ra1", out_ra1, 0);
    chk("arst_rd1", out_rd1, 0);
    chk("arst_rd2", out_rd2, 0);
    chk("arst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_instr = 16'hA01C; sel1 = 2'd1; sel2 = 2'd2; out_ready = 1'b1;
    tick();
    chk("postrst_valid", out_valid, 1);
    chk("postrst_rd1", out_rd1, 0);
    chk("postrst_rd2", out_rd2, 0);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
